imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the decode stage of the pipelined RV32/RV64 core.
- Decodes every RV base immediate format: R, I, S, B, U and J.
- Returns the sign-extended immediate, a format code and an illegal flag, with one cycle of latency.
- A 2-entry skid buffer lets the block sustain full throughput under execute-stage backpressure.
- A saturating counter records how many illegal instructions have been accepted.

Parameters:
- DATA_WIDTH, 32, immediate/datapath width (32 or 64); sign extension always comes from instruction[31].
- ILL_CNT_WIDTH, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  block can accept an instruction.
- in_instruction  input  32  raw instruction word.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_immediate  output  DATA_WIDTH  decoded, sign-extended immediate.
- out_format  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- out_illegal  output  1  opcode is not decodable.
- out_instruction  output  32  instruction passed through, aligned with the result.
- cnt_clear  input  1  clear the illegal counter.
- illegal_count  output  ILL_CNT_WIDTH  count of accepted illegal instructions.

Behaviour:
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Decode by opcode instruction[6:0]:
  - 0010011, 0000011, 1100111: I format, imm = sext(instr[31:20]).
  - 0100011: S format, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011: B format, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111, 0010111: U format, imm = sext({instr[31:12], 12'b0}); upper bits replicate bit 31 when DATA_WIDTH=64.
  - 1101111: J format, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011: R format, imm = 0.
  - Any other opcode, or instr[1:0] != 2'b11: ILL, imm = 0, out_illegal = 1.
- Decode is combinational on the input; the result is captured in the main output register.
- Latency: a result accepted in cycle N is presented with out_valid in cycle N+1.
- Storage: main register (drives the outputs) plus one skid register. in_ready = !skid_valid && !rst.
- On an input transfer:
  - Main empty, or main transferring out this cycle: the new result loads main directly.
  - Otherwise: the new result loads skid.
- On an output transfer:
  - Skid valid: main takes skid and skid empties.
  - Else, input transfer this cycle: main takes the new result.
  - Else: main empties (out_valid = 0).
- Ordering is strictly FIFO. Outputs hold stable while out_valid && !out_ready. No result is lost or duplicated.
- Skid full: in_ready = 0; in_valid is ignored until skid drains.
- Illegal counter, per cycle:
  - cnt_clear = 1: counter goes to 0; clear wins over a simultaneous increment.
  - Else, an input transfer with illegal decode: counter increments, saturating at all ones (no wrap).
- Reset, including mid-transfer:
  - In the cycle after rst: out_valid = 0, skid_valid = 0, out_immediate = 0, out_format = 0, out_illegal = 0, out_instruction = 0, illegal_count = 0.
  - in_ready = 0 while rst is high and 1 in the first cycle after it drops.
  - In-flight entries are discarded.

Decomposition:
- Shared package imm_gen_pkg:
  - Opcode constants: OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP.
  - The 3-bit format enum/localparams: FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL.
- One sub-module: imm_decode, purely combinational (instruction -> immediate, format, illegal), parametrised on DATA_WIDTH.
- The top level holds the main/skid registers, the handshake and the counter.

Test Plan:
- DATA_WIDTH=32, out_ready=1, stream addi 0xFFF00093, sw 0xFE112E23, beq 0xFE000CE3, jal 0x0010006F, lui 0x123452B7 -> one per cycle, immediates 0xFFFFFFFF, 0xFFFFFFFC, 0xFFFFFFF8, 0x00000800, 0x12345000, formats 1, 2, 3, 5, 4, each one cycle after acceptance.
- DATA_WIDTH=64, lui 0x800002B7 -> out_immediate 0xFFFFFFFF80000000; add 0x002081B3 -> immediate 0, format R.
- out_ready=0, three back-to-back valid inputs A, B, C:
  - A held in main, B in skid, in_ready=0, C stalled.
  - Raise out_ready: A, B, C delivered in order on consecutive cycles; no drops.
- ILL_CNT_WIDTH=2, four accepted 0x00000000 words:
  - each -> format 7, out_illegal=1.
  - illegal_count 1, 2, 3, 3 (saturates).
  - cnt_clear with a simultaneous illegal input -> illegal_count 0.
- Fill main and skid with out_ready=0, then pulse rst -> next cycle out_valid=0, illegal_count=0, in_ready=1 after rst drops, and no stale result appears afterwards.
- Random valid/ready toggling, 10k instructions against a reference decoder model -> every immediate, format and instruction matches, in order.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared definitions for the immediate generator.
// Holds the RV base opcodes the decoder recognises and the 3-bit format code
// reported alongside every decoded immediate.
package imm_gen_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder.
// Ports:
//   instruction : raw 32-bit instruction word
//   immediate   : sign-extended immediate, DATA_WIDTH bits (0 for R and ILL)
//   format      : format code (R=0, I=1, S=2, B=3, U=4, J=5, ILL=7)
//   illegal     : opcode not decodable
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instruction,
  output logic [DATA_WIDTH-1:0] immediate,
  output logic [2:0]            format,
  output logic                  illegal
);

  logic signed [31:0] imm32;
  fmt_e               fmt;

  // Every format's sign bit is instruction[31], so building a 32-bit signed
  // value first and widening it gives the right result for RV32 and RV64.
  function automatic logic [DATA_WIDTH-1:0] sext(input logic signed [31:0] v);
    return DATA_WIDTH'(v);
  endfunction

  always_comb begin
    imm32   = '0;
    fmt     = FMT_ILL;
    illegal = 1'b1;
    if (instruction[1:0] == 2'b11) begin
      case (instruction[6:0])
        OP_IMM, LOAD, JALR: begin
          imm32   = {{20{instruction[31]}}, instruction[31:20]};
          fmt     = FMT_I;
          illegal = 1'b0;
        end
        STORE: begin
          imm32   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
          fmt     = FMT_S;
          illegal = 1'b0;
        end
        BRANCH: begin
          imm32   = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
          fmt     = FMT_B;
          illegal = 1'b0;
        end
        LUI, AUIPC: begin
          imm32   = {instruction[31:12], 12'b0};
          fmt     = FMT_U;
          illegal = 1'b0;
        end
        JAL: begin
          imm32   = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};
          fmt     = FMT_J;
          illegal = 1'b0;
        end
        OP: begin
          imm32   = '0;
          fmt     = FMT_R;
          illegal = 1'b0;
        end
        default: begin
          imm32   = '0;
          fmt     = FMT_ILL;
          illegal = 1'b1;
        end
      endcase
    end
  end

  assign immediate = sext(imm32);
  assign format    = fmt;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked immediate generator for the decode stage.
// One cycle of latency; a main output register plus one skid register keep
// full throughput under downstream backpressure, in strict FIFO order.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : upstream handshake, in_instruction is the word
//   out_valid/out_ready      : downstream handshake
//   out_immediate/out_format : decoded immediate and format code
//   out_illegal              : undecodable opcode
//   out_instruction          : instruction aligned with the result
//   cnt_clear/illegal_count  : saturating count of accepted illegal words
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ILL_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instruction,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_immediate,
  output logic [2:0]               out_format,
  output logic                     out_illegal,
  output logic [31:0]              out_instruction,
  input  logic                     cnt_clear,
  output logic [ILL_CNT_WIDTH-1:0] illegal_count
);

  logic [DATA_WIDTH-1:0]    imm_p0;
  logic [2:0]               fmt_p0;
  logic                     ill_p0;

  logic                     vld_p1;
  logic [DATA_WIDTH-1:0]    imm_p1;
  logic [2:0]               fmt_p1;
  logic                     ill_p1;
  logic [31:0]              instr_p1;

  logic                     skid_vld_p1;
  logic [DATA_WIDTH-1:0]    skid_imm_p1;
  logic [2:0]               skid_fmt_p1;
  logic                     skid_ill_p1;
  logic [31:0]              skid_instr_p1;

  logic [ILL_CNT_WIDTH-1:0] cnt;
  logic                     in_xfer;
  logic                     out_xfer;

  // ---- stage p0: combinational decode of the incoming word ----
  imm_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .instruction (in_instruction),
    .immediate   (imm_p0),
    .format      (fmt_p0),
    .illegal     (ill_p0)
  );

  assign in_ready = !skid_vld_p1 && !rst;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = vld_p1 && out_ready;

  // ---- stage p1: main output register and skid register ----
  // Skid only fills when main is occupied and stalled, so in_ready is low
  // whenever skid is valid; skid-to-main and new-to-main never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      imm_p1      <= '0;
      fmt_p1      <= '0;
      ill_p1      <= 1'b0;
      instr_p1    <= '0;
    end else if (out_xfer) begin
      if (skid_vld_p1) begin
        skid_vld_p1 <= 1'b0;
        imm_p1      <= skid_imm_p1;
        fmt_p1      <= skid_fmt_p1;
        ill_p1      <= skid_ill_p1;
        instr_p1    <= skid_instr_p1;
      end else if (in_xfer) begin
        imm_p1      <= imm_p0;
        fmt_p1      <= fmt_p0;
        ill_p1      <= ill_p0;
        instr_p1    <= in_instruction;
      end else begin
        vld_p1      <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!vld_p1) begin
        vld_p1      <= 1'b1;
        imm_p1      <= imm_p0;
        fmt_p1      <= fmt_p0;
        ill_p1      <= ill_p0;
        instr_p1    <= in_instruction;
      end else begin
        skid_vld_p1 <= 1'b1;
      end
    end
  end

  // Skid payload is only meaningful under skid_vld_p1, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_xfer && vld_p1 && !out_xfer) begin
      skid_imm_p1   <= imm_p0;
      skid_fmt_p1   <= fmt_p0;
      skid_ill_p1   <= ill_p0;
      skid_instr_p1 <= in_instruction;
    end
  end

  // Clear has priority over a same-cycle illegal acceptance.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cnt <= '0;
    end else if (in_xfer && ill_p0 && (cnt != '1)) begin
      cnt <= cnt + ILL_CNT_WIDTH'(1);
    end
  end

  assign out_valid       = vld_p1;
  assign out_immediate   = imm_p1;
  assign out_format      = fmt_p1;
  assign out_illegal     = ill_p1;
  assign out_instruction = instr_p1;
  assign illegal_count   = cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instruction;
  logic        out_ready;
  logic        cnt_clear;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32, instr32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;

  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [31:0] instr64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.DATA_WIDTH(32), .ILL_CNT_WIDTH(2)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instruction(in_instruction), .out_valid(out_valid32), .out_ready(out_ready),
    .out_immediate(imm32), .out_format(fmt32), .out_illegal(ill32),
    .out_instruction(instr32), .cnt_clear(cnt_clear), .illegal_count(cnt32)
  );

  imm_gen_pipe #(.DATA_WIDTH(64), .ILL_CNT_WIDTH(16)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instruction(in_instruction), .out_valid(out_valid64), .out_ready(out_ready),
    .out_immediate(imm64), .out_format(fmt64), .out_illegal(ill64),
    .out_instruction(instr64), .cnt_clear(cnt_clear), .illegal_count(cnt64)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decoder: immediates computed with signed arithmetic on the word.
  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] instr;
  } ent_t;

  function automatic ent_t ref_dec(input logic [31:0] w);
    ent_t   e;
    longint s;
    s       = $signed(w);
    e.instr = w;
    e.imm   = 0;
    e.ill   = 1'b0;
    e.fmt   = 3'd7;
    if (w[1:0] != 2'b11) begin
      e.ill = 1'b1;
    end else begin
      case (w[6:0])
        7'h13, 7'h03, 7'h67: begin e.fmt = 1; e.imm = s >>> 20; end
        7'h23: begin e.fmt = 2; e.imm = ((s >>> 25) <<< 5) + longint'(w[11:7]); end
        7'h63: begin
          e.fmt = 3;
          e.imm = ((s >>> 31) <<< 12) + (longint'(w[7]) << 11)
                + (longint'(w[30:25]) << 5) + (longint'(w[11:8]) << 1);
        end
        7'h37, 7'h17: begin e.fmt = 4; e.imm = (s >>> 12) <<< 12; end
        7'h6f: begin
          e.fmt = 5;
          e.imm = ((s >>> 31) <<< 20) + (longint'(w[19:12]) << 12)
                + (longint'(w[20]) << 11) + (longint'(w[30:21]) << 1);
        end
        7'h33: begin e.fmt = 0; e.imm = 0; end
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Model state: queue of results held by the block, and counter values.
  ent_t q[$];
  int   mc32 = 0;
  int   mc64 = 0;
  bit   checking = 1'b0;
  bit   exp_rdy, in_x, out_x;
  ent_t e_new;

  always @(negedge clk) begin
    if (checking) begin
      exp_rdy = !rst && (q.size() < 2);
      chk("in_ready32", in_ready32, exp_rdy);
      chk("in_ready64", in_ready64, exp_rdy);
      chk("out_valid32", out_valid32, q.size() > 0);
      chk("out_valid64", out_valid64, q.size() > 0);
      if (q.size() > 0) begin
        chk("imm32", imm32, q[0].imm[31:0]);
        chk("imm64", imm64, q[0].imm);
        chk("fmt32", fmt32, q[0].fmt);
        chk("fmt64", fmt64, q[0].fmt);
        chk("ill32", ill32, q[0].ill);
        chk("ill64", ill64, q[0].ill);
        chk("instr32", instr32, q[0].instr);
        chk("instr64", instr64, q[0].instr);
      end
      chk("cnt32", cnt32, mc32);
      chk("cnt64", cnt64, mc64);
      if (rst) begin
        q.delete();
        mc32 = 0;
        mc64 = 0;
      end else begin
        in_x  = in_valid && exp_rdy;
        out_x = (q.size() > 0) && out_ready;
        e_new = ref_dec(in_instruction);
        if (cnt_clear) begin
          mc32 = 0;
          mc64 = 0;
        end else if (in_x && e_new.ill) begin
          if (mc32 != 3) mc32++;
          if (mc64 != 65535) mc64++;
        end
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back(e_new);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t1w [5] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h0010006F, 32'h123452B7};
  logic [31:0] t1i [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800, 32'h12345000};
  logic [2:0]  t1f [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4};
  logic [1:0]  t4c [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
  logic [6:0]  ops [9] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33};

  localparam logic [31:0] WA = 32'hFFF00093;
  localparam logic [31:0] WB = 32'hFE112E23;
  localparam logic [31:0] WC = 32'hFE000CE3;

  initial begin
    int   accepted;
    int   cycles;
    ent_t pe;
    logic [31:0] w;

    rst = 1'b1; in_valid = 1'b0; in_instruction = '0; out_ready = 1'b1; cnt_clear = 1'b0;

    pe = ref_dec(32'hFFF00093); chk("model_addi", pe.imm, 64'hFFFFFFFFFFFFFFFF);
    pe = ref_dec(32'hFE000CE3); chk("model_beq", pe.imm, 64'hFFFFFFFFFFFFFFF8);
    pe = ref_dec(32'h0010006F); chk("model_jal", pe.imm, 64'h0000000000000800);
    pe = ref_dec(32'h800002B7); chk("model_lui", pe.imm, 64'hFFFFFFFF80000000);
    pe = ref_dec(32'h00000000); chk("model_ill", {pe.ill, pe.fmt}, 4'hF);

    step(); step();
    checking = 1'b1;
    chk("in_ready_during_rst", in_ready32, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready32, 1'b1);
    chk("rst_out_valid", out_valid32, 1'b0);
    chk("rst_imm", imm64, 64'h0);
    chk("rst_fmt_ill", {fmt32, ill32}, 4'h0);
    chk("rst_instr", instr32, 32'h0);
    chk("rst_cnt", cnt64, 16'h0);

    // Streaming decode at full rate
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instruction = t1w[i];
      step();
      chk("stream_valid", out_valid32, 1'b1);
      chk("stream_imm", imm32, t1i[i]);
      chk("stream_fmt", fmt32, t1f[i]);
    end

    // RV64 sign extension and R format
    in_instruction = 32'h800002B7;
    step();
    chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
    chk("lui32_imm", imm32, 32'h80000000);
    in_instruction = 32'h002081B3;
    step();
    chk("add64_imm", imm64, 64'h0);
    chk("add64_fmt", fmt64, 3'd0);
    in_valid = 1'b0;
    step();

    // Backpressure: A in main, B in skid, C stalled
    out_ready = 1'b0; in_valid = 1'b1; in_instruction = WA;
    step();
    in_instruction = WB;
    step();
    chk("bp_in_ready_full", in_ready32, 1'b0);
    chk("bp_hold_A", instr32, WA);
    in_instruction = WC;
    step();
    chk("bp_stall_A", instr32, WA);
    chk("bp_stall_ready", in_ready32, 1'b0);
    out_ready = 1'b1;
    step();
    chk("bp_deliver_B", instr32, WB);
    chk("bp_ready_again", in_ready32, 1'b1);
    step();
    chk("bp_deliver_C", instr32, WC);
    in_valid = 1'b0;
    step();
    chk("bp_empty", out_valid32, 1'b0);

    // Saturating illegal counter (2-bit on the RV32 instance)
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0; in_valid = 1'b1; in_instruction = 32'h0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ill_fmt", fmt32, 3'd7);
      chk("ill_flag", ill32, 1'b1);
      chk("ill_cnt", cnt32, t4c[k]);
    end
    cnt_clear = 1'b1;
    step();
    chk("clear_wins32", cnt32, 2'd0);
    chk("clear_wins64", cnt64, 16'd0);
    cnt_clear = 1'b0; in_valid = 1'b0;
    step();

    // Reset while main and skid are both full
    out_ready = 1'b0; in_valid = 1'b1; in_instruction = WA;
    step();
    in_instruction = WB;
    step();
    chk("pre_rst_full", in_ready32, 1'b0);
    rst = 1'b1; in_instruction = WC;
    step();
    chk("mid_rst_valid", out_valid32, 1'b0);
    chk("mid_rst_cnt", cnt32, 2'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_ready", in_ready32, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_stale", out_valid32, 1'b0);
    end

    // Random traffic
    accepted = 0;
    cycles   = 0;
    while (accepted < 10000 && cycles < 60000) begin
      w = $urandom;
      if ($urandom_range(9) < 8) w[6:0] = ops[$urandom_range(8)];
      in_instruction = w;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      cnt_clear = ($urandom_range(63) == 0);
      if (in_valid && in_ready32) accepted++;
      step();
      cycles++;
    end
    chk("random_accepted", accepted, 10000);
    in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
    repeat (4) step();
    chk("drained", q.size(), 0);
    checking = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
